// File: rtl/lsu_pipe_if.sv
// Execute-side handshake plus request/grant/response data bus of the load/store unit.
// Latency: none, this is wiring only.
// Backpressure: in_ready on the execute side; bus_gnt and bus_rvalid on the memory side.
interface lsu_pipe_if #(
  parameter int XLEN = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [XLEN-1:0]   exec_result;
  logic [XLEN-1:0]   store_data;
  logic              out_valid;
  logic [XLEN-1:0]   mem_out;
  logic              fault;
  logic [1:0]        fault_cause;
  logic              bus_req;
  logic              bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN/8-1:0] bus_wstrb;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_err;

  // LSU side: consumes instructions, drives the memory bus
  modport master (
    input  in_valid, instr, exec_result, store_data,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err,
    output in_ready, out_valid, mem_out, fault, fault_cause,
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );

  // Environment side: execute stage plus memory
  modport slave (
    output in_valid, instr, exec_result, store_data,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err,
    input  in_ready, out_valid, mem_out, fault, fault_cause,
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/lsu_pipe.sv
// Multi-cycle load/store unit between execute and writeback, one instruction in flight.
// Latency: 2 cycles for passthrough/misaligned; memory ops add grant and response wait.
// Backpressure: in_ready only in IDLE; holds bus_req until bus_gnt; waits for bus_rvalid or timeout.
module lsu_pipe #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic      clk,
  input  logic      rst,
  lsu_pipe_if.master lsu
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;

  logic [XLEN-1:0] addr_q, wdata_q, result_q;
  logic [NB-1:0]   wstrb_q;
  logic [2:0]      f3_q;
  logic            we_q, fault_q;
  logic [1:0]      cause_q;
  logic [CW-1:0]   cnt_q;

  logic [6:0]      op;
  logic [2:0]      f3;
  logic            is_ld, is_st, legal_f3, is_mem, misal;
  logic [OFFW-1:0] off_in;
  logic [NB-1:0]   wstrb_in;
  logic [XLEN-1:0] wdata_in;
  logic [XLEN-1:0] shifted, load_val;
  logic            timeout;

  logic unused_instr;
  assign unused_instr = ^{lsu.instr[31:15], lsu.instr[11:7]};

  // Decode the presented instruction: legality, alignment, lane strobes and replicated data
  always_comb begin
    op       = lsu.instr[6:0];
    f3       = lsu.instr[14:12];
    is_ld    = (op == OP_LOAD);
    is_st    = (op == OP_STORE);
    legal_f3 = 1'b0;
    if (is_ld) begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
        3'b011, 3'b110:                         legal_f3 = (XLEN == 64);
        default:                                legal_f3 = 1'b0;
      endcase
    end else if (is_st) begin
      case (f3)
        3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
        3'b011:                 legal_f3 = (XLEN == 64);
        default:                legal_f3 = 1'b0;
      endcase
    end
    // unsupported func3 under a load/store opcode falls through as a plain passthrough
    is_mem = (is_ld | is_st) & legal_f3;
    off_in = lsu.exec_result[OFFW-1:0];
    case (f3[1:0])
      2'b01:   misal = lsu.exec_result[0];
      2'b10:   misal = |lsu.exec_result[1:0];
      2'b11:   misal = |lsu.exec_result[2:0];
      default: misal = 1'b0;
    endcase
    case (f3[1:0])
      2'b00:   wstrb_in = NB'(1) << off_in;
      2'b01:   wstrb_in = NB'(3) << off_in;
      2'b10:   wstrb_in = NB'(4'hF) << off_in;
      default: wstrb_in = {NB{1'b1}};
    endcase
    case (f3[1:0])
      2'b00:   wdata_in = {NB{lsu.store_data[7:0]}};
      2'b01:   wdata_in = {(XLEN/16){lsu.store_data[15:0]}};
      2'b10:   wdata_in = {(XLEN/32){lsu.store_data[31:0]}};
      default: wdata_in = lsu.store_data;
    endcase
  end

  // Align returned lane down to bit 0, then sign- or zero-extend by access size
  always_comb begin
    shifted = lsu.bus_rdata >> {addr_q[OFFW-1:0], 3'b000};
    case (f3_q)
      3'b000:  load_val = XLEN'($signed(shifted[7:0]));
      3'b001:  load_val = XLEN'($signed(shifted[15:0]));
      3'b010:  load_val = XLEN'($signed(shifted[31:0]));
      3'b100:  load_val = XLEN'(shifted[7:0]);
      3'b101:  load_val = XLEN'(shifted[15:0]);
      3'b110:  load_val = XLEN'(shifted[31:0]);
      default: load_val = shifted;
    endcase
  end

  // Next-state logic; a response in the same cycle as the timeout takes priority
  always_comb begin
    state_d = state_q;
    timeout = TO_EN && (cnt_q == CNT_LAST);
    case (state_q)
      S_IDLE: if (lsu.in_valid) state_d = (is_mem && !misal) ? S_REQ : S_DONE;
      S_REQ:  if (lsu.bus_gnt) state_d = S_WAIT;
      S_WAIT: if (lsu.bus_rvalid || timeout) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Operand capture at acceptance, result/fault capture at completion, WAIT cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      wstrb_q  <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      cause_q  <= 2'b00;
      cnt_q    <= '0;
    end else begin
      cnt_q <= (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
      if (state_q == S_IDLE && lsu.in_valid) begin
        addr_q   <= lsu.exec_result;
        f3_q     <= f3;
        we_q     <= is_mem & is_st;
        wstrb_q  <= (is_mem && is_st && !misal) ? wstrb_in : '0;
        wdata_q  <= wdata_in;
        result_q <= lsu.exec_result;
        fault_q  <= is_mem & misal;
        cause_q  <= (is_mem && misal) ? (is_st ? 2'b10 : 2'b01) : 2'b00;
      end else if (state_q == S_WAIT) begin
        if (lsu.bus_rvalid && !lsu.bus_err) begin
          result_q <= we_q ? '0 : load_val;
        end else if (lsu.bus_rvalid || timeout) begin
          result_q <= addr_q;
          fault_q  <= 1'b1;
          cause_q  <= 2'b11;
        end
      end
    end
  end

  assign lsu.in_ready    = (state_q == S_IDLE);
  assign lsu.out_valid   = (state_q == S_DONE);
  assign lsu.fault       = (state_q == S_DONE) & fault_q;
  assign lsu.fault_cause = cause_q;
  assign lsu.mem_out     = result_q;
  assign lsu.bus_req     = (state_q == S_REQ);
  assign lsu.bus_we      = we_q;
  assign lsu.bus_addr    = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign lsu.bus_wstrb   = wstrb_q;
  assign lsu.bus_wdata   = wdata_q;
endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: one 32-bit instance with a short timeout, one 64-bit instance.
// Inputs change and outputs are sampled on the falling edge.
// Memory bus responses are scripted cycle by cycle.
module tb_lsu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [6:0] OPL = 7'b0000011;
  localparam logic [6:0] OPS = 7'b0100011;
  localparam logic [6:0] OPI = 7'b0010011;

  always #5 clk = ~clk;

  lsu_pipe_if #(.XLEN(32)) i32 ();
  lsu_pipe_if #(.XLEN(64)) i64 ();

  lsu_pipe #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut32 (.clk(clk), .rst(rst), .lsu(i32));
  lsu_pipe #(.XLEN(64))                     dut64 (.clk(clk), .rst(rst), .lsu(i64));

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd1, op};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(); step();
    n_cmp++; if (i32.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %h exp 1", i32.in_ready); end
    n_cmp++; if (i32.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %h exp 0", i32.out_valid); end
    n_cmp++; if (i32.fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault got %h exp 0", i32.fault); end
    n_cmp++; if (i32.bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_bus_req got %h exp 0", i32.bus_req); end
    n_cmp++; if (i32.bus_we !== 1'b0) begin n_bad++; $display("FAIL rst_bus_we got %h exp 0", i32.bus_we); end
    n_cmp++; if (i32.fault_cause !== 2'b00) begin n_bad++; $display("FAIL rst_cause got %h exp 0", i32.fault_cause); end
    n_cmp++; if (i32.mem_out !== 32'h0) begin n_bad++; $display("FAIL rst_mem_out got %h exp 0", i32.mem_out); end
    n_cmp++; if (i32.bus_addr !== 32'h0) begin n_bad++; $display("FAIL rst_bus_addr got %h exp 0", i32.bus_addr); end
    n_cmp++; if (i32.bus_wstrb !== 4'h0) begin n_bad++; $display("FAIL rst_wstrb got %h exp 0", i32.bus_wstrb); end
    n_cmp++; if (i32.bus_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata got %h exp 0", i32.bus_wdata); end
    n_cmp++; if (i64.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst64_in_ready got %h exp 1", i64.in_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_byte();
    i32.instr = mk(OPL, 3'b000); i32.exec_result = 32'h1003; i32.in_valid = 1'b1;
    step();
    i32.in_valid = 1'b0;
    n_cmp++; if (i32.bus_req !== 1'b1) begin n_bad++; $display("FAIL lb_req got %h exp 1", i32.bus_req); end
    n_cmp++; if (i32.bus_addr !== 32'h1000) begin n_bad++; $display("FAIL lb_addr got %h exp 00001000", i32.bus_addr); end
    n_cmp++; if (i32.bus_wstrb !== 4'h0) begin n_bad++; $display("FAIL lb_wstrb got %h exp 0", i32.bus_wstrb); end
    n_cmp++; if (i32.in_ready !== 1'b0) begin n_bad++; $display("FAIL lb_in_ready got %h exp 0", i32.in_ready); end
    i32.bus_gnt = 1'b1;
    step();
    i32.bus_gnt = 1'b0;
    n_cmp++; if (i32.bus_req !== 1'b0) begin n_bad++; $display("FAIL lb_req_drop got %h exp 0", i32.bus_req); end
    step();
    n_cmp++; if (i32.out_valid !== 1'b0) begin n_bad++; $display("FAIL lb_early_valid got %h exp 0", i32.out_valid); end
    i32.bus_rvalid = 1'b1; i32.bus_rdata = 32'h80FF_1234;
    step();
    i32.bus_rvalid = 1'b0;
    n_cmp++; if (i32.out_valid !== 1'b1) begin n_bad++; $display("FAIL lb_valid got %h exp 1", i32.out_valid); end
    n_cmp++; if (i32.mem_out !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data got %h exp ffffff80", i32.mem_out); end
    n_cmp++; if (i32.fault !== 1'b0) begin n_bad++; $display("FAIL lb_fault got %h exp 0", i32.fault); end
    step();
    n_cmp++; if (i32.out_valid !== 1'b0) begin n_bad++; $display("FAIL lb_pulse got %h exp 0", i32.out_valid); end
    n_cmp++; if (i32.in_ready !== 1'b1) begin n_bad++; $display("FAIL lb_ready_back got %h exp 1", i32.in_ready); end
  endtask

  task automatic test_store_half();
    i32.instr = mk(OPS, 3'b001); i32.exec_result = 32'h2002; i32.store_data = 32'hDEAD_BEEF; i32.in_valid = 1'b1;
    step();
    i32.in_valid = 1'b0;
    n_cmp++; if (i32.bus_we !== 1'b1) begin n_bad++; $display("FAIL sh_we got %h exp 1", i32.bus_we); end
    n_cmp++; if (i32.bus_wstrb !== 4'b1100) begin n_bad++; $display("FAIL sh_wstrb got %b exp 1100", i32.bus_wstrb); end
    n_cmp++; if (i32.bus_wdata !== 32'hBEEF_BEEF) begin n_bad++; $display("FAIL sh_wdata got %h exp beefbeef", i32.bus_wdata); end
    n_cmp++; if (i32.bus_addr !== 32'h2000) begin n_bad++; $display("FAIL sh_addr got %h exp 00002000", i32.bus_addr); end
    step();
    n_cmp++; if (i32.bus_req !== 1'b1) begin n_bad++; $display("FAIL sh_req_hold got %h exp 1", i32.bus_req); end
    n_cmp++; if (i32.bus_wstrb !== 4'b1100) begin n_bad++; $display("FAIL sh_wstrb_hold got %b exp 1100", i32.bus_wstrb); end
    i32.bus_gnt = 1'b1;
    step();
    i32.bus_gnt = 1'b0;
    n_cmp++; if (i32.bus_req !== 1'b0) begin n_bad++; $display("FAIL sh_req_drop got %h exp 0", i32.bus_req); end
    i32.bus_rvalid = 1'b1; i32.bus_err = 1'b0;
    step();
    i32.bus_rvalid = 1'b0;
    n_cmp++; if (i32.out_valid !== 1'b1) begin n_bad++; $display("FAIL sh_valid got %h exp 1", i32.out_valid); end
    n_cmp++; if (i32.fault !== 1'b0) begin n_bad++; $display("FAIL sh_fault got %h exp 0", i32.fault); end
    step();
  endtask

  task automatic test_misaligned();
    i32.instr = mk(OPL, 3'b010); i32.exec_result = 32'h3001; i32.in_valid = 1'b1;
    step();
    i32.in_valid = 1'b0;
    n_cmp++; if (i32.bus_req !== 1'b0) begin n_bad++; $display("FAIL lw_mis_req got %h exp 0", i32.bus_req); end
    n_cmp++; if (i32.out_valid !== 1'b1) begin n_bad++; $display("FAIL lw_mis_valid got %h exp 1", i32.out_valid); end
    n_cmp++; if (i32.fault !== 1'b1) begin n_bad++; $display("FAIL lw_mis_fault got %h exp 1", i32.fault); end
    n_cmp++; if (i32.fault_cause !== 2'b01) begin n_bad++; $display("FAIL lw_mis_cause got %b exp 01", i32.fault_cause); end
    n_cmp++; if (i32.mem_out !== 32'h3001) begin n_bad++; $display("FAIL lw_mis_addr got %h exp 00003001", i32.mem_out); end
    i32.instr = mk(OPS, 3'b010); i32.exec_result = 32'h3002; i32.in_valid = 1'b1;
    step();
    n_cmp++; if (i32.out_valid !== 1'b0) begin n_bad++; $display("FAIL sw_mis_busy got %h exp 0", i32.out_valid); end
    step();
    i32.in_valid = 1'b0;
    n_cmp++; if (i32.fault_cause !== 2'b10) begin n_bad++; $display("FAIL sw_mis_cause got %b exp 10", i32.fault_cause); end
    n_cmp++; if (i32.mem_out !== 32'h3002) begin n_bad++; $display("FAIL sw_mis_addr got %h exp 00003002", i32.mem_out); end
    n_cmp++; if (i32.bus_req !== 1'b0) begin n_bad++; $display("FAIL sw_mis_req got %h exp 0", i32.bus_req); end
    step();
  endtask

  task automatic test_passthrough_bad_f3();
    i32.instr = mk(OPL, 3'b011); i32.exec_result = 32'h55; i32.in_valid = 1'b1;
    step();
    i32.in_valid = 1'b0;
    n_cmp++; if (i32.out_valid !== 1'b1 || i32.bus_req !== 1'b0) begin n_bad++; $display("FAIL ld32_pass got valid %h req %h exp 1 0", i32.out_valid, i32.bus_req); end
    n_cmp++; if (i32.mem_out !== 32'h55 || i32.fault !== 1'b0) begin n_bad++; $display("FAIL ld32_data got %h fault %h exp 00000055 0", i32.mem_out, i32.fault); end
    step();
  endtask

  task automatic test_timeout();
    i32.instr = mk(OPL, 3'b010); i32.exec_result = 32'h4000; i32.in_valid = 1'b1;
    step();
    i32.in_valid = 1'b0; i32.bus_gnt = 1'b1;
    step();
    i32.bus_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (i32.out_valid !== 1'b0) begin n_bad++; $display("FAIL to_early%0d got %h exp 0", k, i32.out_valid); end
    end
    step();
    n_cmp++; if (i32.out_valid !== 1'b1) begin n_bad++; $display("FAIL to_valid got %h exp 1", i32.out_valid); end
    n_cmp++; if (i32.fault !== 1'b1 || i32.fault_cause !== 2'b11) begin n_bad++; $display("FAIL to_cause got fault %h cause %b exp 1 11", i32.fault, i32.fault_cause); end
    n_cmp++; if (i32.mem_out !== 32'h4000) begin n_bad++; $display("FAIL to_addr got %h exp 00004000", i32.mem_out); end
    i32.bus_rvalid = 1'b1; i32.bus_rdata = 32'h1111_1111;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++; if (i32.out_valid !== 1'b0) begin n_bad++; $display("FAIL to_late%0d got %h exp 0", k, i32.out_valid); end
    end
    i32.bus_rvalid = 1'b0;
  endtask

  task automatic test_xlen64();
    i64.instr = mk(OPL, 3'b110); i64.exec_result = 64'h0000_0000_0000_1004; i64.in_valid = 1'b1;
    step();
    i64.in_valid = 1'b0;
    n_cmp++; if (i64.bus_addr !== 64'h1000) begin n_bad++; $display("FAIL lwu_addr got %h exp 1000", i64.bus_addr); end
    i64.bus_gnt = 1'b1;
    step();
    i64.bus_gnt = 1'b0; i64.bus_rvalid = 1'b1; i64.bus_rdata = 64'h8000_0001_0000_0000;
    step();
    i64.bus_rvalid = 1'b0;
    n_cmp++; if (i64.out_valid !== 1'b1) begin n_bad++; $display("FAIL lwu_valid got %h exp 1", i64.out_valid); end
    n_cmp++; if (i64.mem_out !== 64'h0000_0000_8000_0001) begin n_bad++; $display("FAIL lwu_data got %h exp 0000000080000001", i64.mem_out); end
    step();
    i64.instr = mk(OPI, 3'b000); i64.exec_result = 64'h42; i64.in_valid = 1'b1;
    step();
    i64.in_valid = 1'b0;
    n_cmp++; if (i64.out_valid !== 1'b1 || i64.mem_out !== 64'h42) begin n_bad++; $display("FAIL addi got valid %h data %h exp 1 42", i64.out_valid, i64.mem_out); end
    step();
    n_cmp++; if (i64.out_valid !== 1'b0) begin n_bad++; $display("FAIL addi_pulse got %h exp 0", i64.out_valid); end
    i64.instr = mk(OPS, 3'b000); i64.exec_result = 64'h2005; i64.store_data = 64'h0123_4567_89AB_CDAB; i64.in_valid = 1'b1;
    step();
    i64.in_valid = 1'b0;
    n_cmp++; if (i64.bus_wstrb !== 8'h20) begin n_bad++; $display("FAIL sb64_wstrb got %h exp 20", i64.bus_wstrb); end
    n_cmp++; if (i64.bus_wdata !== 64'hABAB_ABAB_ABAB_ABAB) begin n_bad++; $display("FAIL sb64_wdata got %h exp abababababababab", i64.bus_wdata); end
    i64.bus_gnt = 1'b1;
    step();
    i64.bus_gnt = 1'b0; i64.bus_rvalid = 1'b1; i64.bus_err = 1'b1;
    step();
    i64.bus_rvalid = 1'b0; i64.bus_err = 1'b0;
    n_cmp++; if (i64.fault !== 1'b1 || i64.fault_cause !== 2'b11) begin n_bad++; $display("FAIL sb64_err got fault %h cause %b exp 1 11", i64.fault, i64.fault_cause); end
    n_cmp++; if (i64.mem_out !== 64'h2005) begin n_bad++; $display("FAIL sb64_err_addr got %h exp 2005", i64.mem_out); end
    step();
  endtask

  task automatic test_reset_mid();
    i32.instr = mk(OPL, 3'b010); i32.exec_result = 32'h5000; i32.in_valid = 1'b1;
    step();
    i32.in_valid = 1'b0; i32.bus_gnt = 1'b1;
    step();
    i32.bus_gnt = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (i32.bus_req !== 1'b0 || i32.in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_state got req %h ready %h exp 0 1", i32.bus_req, i32.in_ready); end
    n_cmp++; if (i32.out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %h exp 0", i32.out_valid); end
    i32.bus_rvalid = 1'b1; i32.bus_rdata = 32'hAAAA_AAAA;
    step();
    i32.bus_rvalid = 1'b0;
    n_cmp++; if (i32.out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_late got %h exp 0", i32.out_valid); end
    i32.instr = mk(OPL, 3'b010); i32.exec_result = 32'h6004; i32.in_valid = 1'b1;
    step();
    i32.in_valid = 1'b0; i32.bus_gnt = 1'b1;
    n_cmp++; if (i32.bus_req !== 1'b1 || i32.bus_addr !== 32'h6004) begin n_bad++; $display("FAIL rmid2_req got req %h addr %h exp 1 00006004", i32.bus_req, i32.bus_addr); end
    step();
    i32.bus_gnt = 1'b0; i32.bus_rvalid = 1'b1; i32.bus_rdata = 32'h1234_5678;
    step();
    i32.bus_rvalid = 1'b0;
    n_cmp++; if (i32.out_valid !== 1'b1 || i32.mem_out !== 32'h1234_5678) begin n_bad++; $display("FAIL rmid2_data got valid %h data %h exp 1 12345678", i32.out_valid, i32.mem_out); end
    step();
  endtask

  initial begin
    i32.in_valid = 1'b0; i32.instr = '0; i32.exec_result = '0; i32.store_data = '0;
    i32.bus_gnt = 1'b0; i32.bus_rvalid = 1'b0; i32.bus_rdata = '0; i32.bus_err = 1'b0;
    i64.in_valid = 1'b0; i64.instr = '0; i64.exec_result = '0; i64.store_data = '0;
    i64.bus_gnt = 1'b0; i64.bus_rvalid = 1'b0; i64.bus_rdata = '0; i64.bus_err = 1'b0;
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_passthrough_bad_f3();
    test_timeout();
    test_xlen64();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
